// File: rtl/mesi_pkg.sv
// -----------------------------------------------------------------------------
// mesi_pkg
// Shared encodings for the L2 MESI line-state keeper: line states, command
// codes, snoop results and bus operations, plus the illegal-command check.
// No ports (package).
// -----------------------------------------------------------------------------
package mesi_pkg;

    // Line state encoding; I is deliberately all-ones so a cleared line reads 2'b11
    typedef enum logic [1:0] {
        ST_M = 2'b00,
        ST_E = 2'b01,
        ST_S = 2'b10,
        ST_I = 2'b11
    } mesi_state_e;

    typedef enum logic [3:0] {
        CMD_L1_READ   = 4'b0000,
        CMD_L1_WRITE  = 4'b0001,
        CMD_L1_IREAD  = 4'b0010,
        CMD_SNP_INV   = 4'b0011,
        CMD_SNP_READ  = 4'b0100,
        CMD_SNP_WRITE = 4'b0101,
        CMD_SNP_RFO   = 4'b0110,
        CMD_CLEAR     = 4'b1000,
        CMD_PRINT     = 4'b1001
    } mesi_cmd_e;

    typedef enum logic [1:0] {
        SNP_NOHIT = 2'b00,
        SNP_HIT   = 2'b01,
        SNP_HITM  = 2'b10
    } mesi_snoop_e;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_READ  = 3'd1,
        OP_WRITE = 3'd2,
        OP_INVAL = 3'd3,
        OP_RWIM  = 3'd4
    } mesi_bus_op_e;

    // Codes 0111 and 1010..1111 have no meaning
    function automatic logic is_illegal_cmd(input logic [3:0] code);
        return (code == 4'b0111) || (code >= 4'b1010);
    endfunction

endpackage

// File: rtl/mesi_line_state_ctrl_if.sv
// -----------------------------------------------------------------------------
// mesi_line_state_ctrl_if
// Command/response bundle between the L2 tag logic (master) and the MESI
// line-state keeper (slave).
//   cmd_*      : valid/ready command with set/way index and external snoop_in
//   rsp_*      : registered one-cycle response
//   busy       : clear/reset sweep in progress
//   hit_cnt, miss_cnt, wb_cnt : statistics, only when MESI_STATS_EN is defined
// -----------------------------------------------------------------------------
interface mesi_line_state_ctrl_if #(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 4,
    parameter int CNT_W    = 16
);
    localparam int SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_code;
    logic [SET_W-1:0] cmd_set;
    logic [WAY_W-1:0] cmd_way;
    logic [1:0]       snoop_in;
    logic             rsp_valid;
    logic [1:0]       rsp_prev_state;
    logic [1:0]       rsp_next_state;
    logic [2:0]       rsp_bus_op;
    logic [1:0]       rsp_snoop_out;
    logic             rsp_illegal;
    logic             busy;
`ifdef MESI_STATS_EN
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic [CNT_W-1:0] wb_cnt;

    modport master (
        output cmd_valid, cmd_code, cmd_set, cmd_way, snoop_in,
        input  cmd_ready, rsp_valid, rsp_prev_state, rsp_next_state,
               rsp_bus_op, rsp_snoop_out, rsp_illegal, busy,
               hit_cnt, miss_cnt, wb_cnt
    );
    modport slave (
        input  cmd_valid, cmd_code, cmd_set, cmd_way, snoop_in,
        output cmd_ready, rsp_valid, rsp_prev_state, rsp_next_state,
               rsp_bus_op, rsp_snoop_out, rsp_illegal, busy,
               hit_cnt, miss_cnt, wb_cnt
    );
`else
    modport master (
        output cmd_valid, cmd_code, cmd_set, cmd_way, snoop_in,
        input  cmd_ready, rsp_valid, rsp_prev_state, rsp_next_state,
               rsp_bus_op, rsp_snoop_out, rsp_illegal, busy
    );
    modport slave (
        input  cmd_valid, cmd_code, cmd_set, cmd_way, snoop_in,
        output cmd_ready, rsp_valid, rsp_prev_state, rsp_next_state,
               rsp_bus_op, rsp_snoop_out, rsp_illegal, busy
    );
`endif
endinterface

// File: rtl/mesi_next_state.sv
// -----------------------------------------------------------------------------
// mesi_next_state
// Pure combinational MESI transition table for one line.
//   cur_state  in  : present line state
//   cmd        in  : 4-bit command code
//   snoop_in   in  : other caches' snoop result for our bus read
//   next_state out : state to write back
//   bus_op     out : bus operation we must issue
//   snoop_out  out : our snoop answer
//   illegal    out : unknown command or snoop_in = 11 (state is left alone)
// -----------------------------------------------------------------------------
module mesi_next_state
    import mesi_pkg::*;
(
    input  mesi_state_e  cur_state,
    input  logic [3:0]   cmd,
    input  logic [1:0]   snoop_in,
    output mesi_state_e  next_state,
    output mesi_bus_op_e bus_op,
    output mesi_snoop_e  snoop_out,
    output logic         illegal
);

    // Transition table; clear and print fall through to "no change"
    always_comb begin
        next_state = cur_state;
        bus_op     = OP_NONE;
        snoop_out  = SNP_NOHIT;
        illegal    = is_illegal_cmd(cmd) || (snoop_in == 2'b11);
        if (illegal) begin
            next_state = cur_state;
        end else begin
            case (cmd)
                CMD_L1_READ, CMD_L1_IREAD: begin
                    if (cur_state == ST_I) begin
                        // Exclusive only when nobody else holds the line
                        next_state = (snoop_in == 2'b00) ? ST_E : ST_S;
                        bus_op     = OP_READ;
                    end else begin
                        next_state = cur_state;
                    end
                end
                CMD_L1_WRITE: begin
                    next_state = ST_M;
                    case (cur_state)
                        ST_I:    bus_op = OP_RWIM;
                        ST_S:    bus_op = OP_INVAL;
                        default: bus_op = OP_NONE;
                    endcase
                end
                CMD_SNP_INV: begin
                    if (cur_state == ST_S) begin
                        next_state = ST_I;
                        snoop_out  = SNP_HIT;
                    end else begin
                        next_state = cur_state;
                    end
                end
                CMD_SNP_READ: begin
                    case (cur_state)
                        ST_M: begin
                            next_state = ST_S;
                            snoop_out  = SNP_HITM;
                            bus_op     = OP_WRITE;
                        end
                        ST_E, ST_S: begin
                            next_state = ST_S;
                            snoop_out  = SNP_HIT;
                        end
                        default: next_state = cur_state;
                    endcase
                end
                CMD_SNP_RFO: begin
                    case (cur_state)
                        ST_M: begin
                            next_state = ST_I;
                            snoop_out  = SNP_HITM;
                            bus_op     = OP_WRITE;
                        end
                        ST_E, ST_S: begin
                            next_state = ST_I;
                            snoop_out  = SNP_HIT;
                        end
                        default: next_state = cur_state;
                    endcase
                end
                default: next_state = cur_state;
            endcase
        end
    end

endmodule

// File: rtl/mesi_line_state_ctrl.sv
// -----------------------------------------------------------------------------
// mesi_line_state_ctrl
// MESI state keeper for a NUM_SETS x NUM_WAYS L2: per-line state array,
// clear/reset sweep (one set per cycle), valid/ready command intake and a
// registered one-cycle response.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mesi_line_state_ctrl_if.slave (commands in, responses out)
// Optional: define MESI_STATS_EN for saturating hit/miss/writeback counters.
// -----------------------------------------------------------------------------
module mesi_line_state_ctrl
    import mesi_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 4,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mesi_line_state_ctrl_if.slave bus
);
    localparam int               SET_W    = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
    localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);

    mesi_state_e      state_r [NUM_SETS][NUM_WAYS];
    logic             busy_r;
    logic             clr_sweep_r;
    logic [SET_W-1:0] sweep_idx_r;
    logic             rsp_valid_r;
    mesi_state_e      rsp_prev_r;
    mesi_state_e      rsp_next_r;
    mesi_bus_op_e     rsp_bus_op_r;
    mesi_snoop_e      rsp_snoop_r;
    logic             rsp_illegal_r;

    logic             cmd_ready_s;
    logic             accept_s;
    logic             clear_cmd_s;
    logic             sweep_last_s;
    mesi_state_e      cur_state_s;
    mesi_state_e      nxt_state_s;
    mesi_bus_op_e     bus_op_s;
    mesi_snoop_e      snoop_out_s;
    logic             illegal_s;

    // busy_r is preset during rst so the reset sweep starts on the first
    // cycle after rst falls; masking with rst keeps busy low while in reset.
    assign cmd_ready_s  = ~busy_r & ~rst;
    assign accept_s     = bus.cmd_valid & cmd_ready_s;
    assign cur_state_s  = state_r[bus.cmd_set][bus.cmd_way];
    assign clear_cmd_s  = (bus.cmd_code == CMD_CLEAR) & ~illegal_s;
    assign sweep_last_s = (sweep_idx_r == LAST_SET);

    mesi_next_state u_next (
        .cur_state  (cur_state_s),
        .cmd        (bus.cmd_code),
        .snoop_in   (bus.snoop_in),
        .next_state (nxt_state_s),
        .bus_op     (bus_op_s),
        .snoop_out  (snoop_out_s),
        .illegal    (illegal_s)
    );

    // State array: whole-set invalidate while sweeping, else single-line update
    always_ff @(posedge clk) begin
        if (rst) begin
            // array contents are rebuilt by the sweep that follows reset
        end else if (busy_r) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                state_r[sweep_idx_r][w] <= ST_I;
            end
        end else if (accept_s && !illegal_s) begin
            state_r[bus.cmd_set][bus.cmd_way] <= nxt_state_s;
        end
    end

    // Sweep sequencer: reset sweep (silent) or clear sweep (answers at the end)
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r      <= 1'b1;
            clr_sweep_r <= 1'b0;
            sweep_idx_r <= '0;
        end else if (busy_r) begin
            if (sweep_last_s) begin
                busy_r      <= 1'b0;
                sweep_idx_r <= '0;
            end else begin
                sweep_idx_r <= sweep_idx_r + 1'b1;
            end
        end else if (accept_s && clear_cmd_s) begin
            busy_r      <= 1'b1;
            clr_sweep_r <= 1'b1;
            sweep_idx_r <= '0;
        end
    end

    // Response registers: one-cycle pulse per accepted command or finished clear
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r   <= 1'b0;
            rsp_prev_r    <= ST_I;
            rsp_next_r    <= ST_I;
            rsp_bus_op_r  <= OP_NONE;
            rsp_snoop_r   <= SNP_NOHIT;
            rsp_illegal_r <= 1'b0;
        end else if (busy_r && sweep_last_s && clr_sweep_r) begin
            rsp_valid_r   <= 1'b1;
            rsp_prev_r    <= ST_I;
            rsp_next_r    <= ST_I;
            rsp_bus_op_r  <= OP_NONE;
            rsp_snoop_r   <= SNP_NOHIT;
            rsp_illegal_r <= 1'b0;
        end else if (accept_s && !clear_cmd_s) begin
            rsp_valid_r   <= 1'b1;
            rsp_prev_r    <= cur_state_s;
            rsp_next_r    <= nxt_state_s;
            rsp_bus_op_r  <= bus_op_s;
            rsp_snoop_r   <= snoop_out_s;
            rsp_illegal_r <= illegal_s;
        end else begin
            rsp_valid_r   <= 1'b0;
        end
    end

    assign bus.cmd_ready      = cmd_ready_s;
    assign bus.busy           = busy_r & ~rst;
    assign bus.rsp_valid      = rsp_valid_r;
    assign bus.rsp_prev_state = rsp_prev_r;
    assign bus.rsp_next_state = rsp_next_r;
    assign bus.rsp_bus_op     = rsp_bus_op_r;
    assign bus.rsp_snoop_out  = rsp_snoop_r;
    assign bus.rsp_illegal    = rsp_illegal_r;

`ifdef MESI_STATS_EN
    logic [CNT_W-1:0] hit_cnt_r;
    logic [CNT_W-1:0] miss_cnt_r;
    logic [CNT_W-1:0] wb_cnt_r;
    logic             l1_cmd_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign l1_cmd_s = (bus.cmd_code == CMD_L1_READ) || (bus.cmd_code == CMD_L1_WRITE) ||
                      (bus.cmd_code == CMD_L1_IREAD);

    // Statistics: zeroed by reset and by an accepted clear, saturating otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_r  <= '0;
            miss_cnt_r <= '0;
            wb_cnt_r   <= '0;
        end else if (accept_s && clear_cmd_s) begin
            hit_cnt_r  <= '0;
            miss_cnt_r <= '0;
            wb_cnt_r   <= '0;
        end else if (accept_s && !illegal_s) begin
            if (l1_cmd_s && (cur_state_s == ST_I)) miss_cnt_r <= sat_inc(miss_cnt_r);
            if (l1_cmd_s && (cur_state_s != ST_I)) hit_cnt_r  <= sat_inc(hit_cnt_r);
            if (bus_op_s == OP_WRITE)              wb_cnt_r   <= sat_inc(wb_cnt_r);
        end
    end

    assign bus.hit_cnt  = hit_cnt_r;
    assign bus.miss_cnt = miss_cnt_r;
    assign bus.wb_cnt   = wb_cnt_r;
`endif

endmodule

// File: tb/tb_mesi_line_state_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mesi_line_state_ctrl
// Directed bench for mesi_line_state_ctrl (NUM_SETS=16, NUM_WAYS=4).
// Commands are driven on the falling edge; responses are sampled 1 time unit
// after the rising edge that accepted the command. Counter checks are active
// when MESI_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_mesi_line_state_ctrl;
    localparam int NUM_SETS = 16;
    localparam int NUM_WAYS = 4;
    localparam int CNT_W    = 16;

    localparam logic [3:0] C_RD    = 4'b0000;
    localparam logic [3:0] C_WR    = 4'b0001;
    localparam logic [3:0] C_IRD   = 4'b0010;
    localparam logic [3:0] C_SINV  = 4'b0011;
    localparam logic [3:0] C_SRD   = 4'b0100;
    localparam logic [3:0] C_SWR   = 4'b0101;
    localparam logic [3:0] C_SRFO  = 4'b0110;
    localparam logic [3:0] C_CLR   = 4'b1000;
    localparam logic [3:0] C_PRINT = 4'b1001;

    logic clk = 1'b0;
    logic rst;
    int   tests  = 0;
    int   failed = 0;
    int   cyc;
    int   seen;

    always #5 clk = ~clk;

    mesi_line_state_ctrl_if #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS), .CNT_W(CNT_W)) bus_if ();

    mesi_line_state_ctrl #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] code, input int set, input int way, input logic [1:0] snp);
        @(negedge clk);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_code  = code;
        bus_if.cmd_set   = set[3:0];
        bus_if.cmd_way   = way[1:0];
        bus_if.snoop_in  = snp;
        @(posedge clk);
        #1;
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic chk_rsp(input string tag, input logic [1:0] prev, input logic [1:0] nxt,
                           input logic [2:0] op, input logic [1:0] snp, input logic ill);
        chk({tag, ".valid"},   bus_if.rsp_valid,      32'd1);
        chk({tag, ".prev"},    bus_if.rsp_prev_state, prev);
        chk({tag, ".next"},    bus_if.rsp_next_state, nxt);
        chk({tag, ".bus_op"},  bus_if.rsp_bus_op,     op);
        chk({tag, ".snoop"},   bus_if.rsp_snoop_out,  snp);
        chk({tag, ".illegal"}, bus_if.rsp_illegal,    ill);
    endtask

    // Counts busy cycles from the current sample point, bounded
    task automatic watch_sweep(output int cycles, output int rsp_seen);
        int guard = 0;
        cycles   = 0;
        rsp_seen = 0;
        while (bus_if.busy === 1'b1 && guard < 200) begin
            cycles++;
            if (bus_if.rsp_valid === 1'b1) rsp_seen++;
            @(posedge clk);
            #1;
            guard++;
        end
        chk("sweep_bounded", (guard < 200) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_code  = 4'b0000;
        bus_if.cmd_set   = 4'd0;
        bus_if.cmd_way   = 2'd0;
        bus_if.snoop_in  = 2'b00;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready",   bus_if.cmd_ready,      32'd0);
        chk("rst.busy",    bus_if.busy,           32'd0);
        chk("rst.valid",   bus_if.rsp_valid,      32'd0);
        chk("rst.prev",    bus_if.rsp_prev_state, 32'd3);
        chk("rst.next",    bus_if.rsp_next_state, 32'd3);
        chk("rst.bus_op",  bus_if.rsp_bus_op,     32'd0);
        chk("rst.snoop",   bus_if.rsp_snoop_out,  32'd0);
        chk("rst.illegal", bus_if.rsp_illegal,    32'd0);

        // Reset sweep: NUM_SETS busy cycles, silent
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("init.busy",  bus_if.busy,      32'd1);
        chk("init.ready", bus_if.cmd_ready, 32'd0);
        watch_sweep(cyc, seen);
        chk("init.len",       cyc,              32'd16);
        chk("init.no_rsp",    seen,             32'd0);
        chk("init.no_rsp_end", bus_if.rsp_valid, 32'd0);
        chk("init.ready_end", bus_if.cmd_ready, 32'd1);
`ifdef MESI_STATS_EN
        chk("init.hit_cnt",  bus_if.hit_cnt,  32'd0);
        chk("init.miss_cnt", bus_if.miss_cnt, 32'd0);
        chk("init.wb_cnt",   bus_if.wb_cnt,   32'd0);
`endif

        send(C_PRINT, 3, 2, 2'b00);  chk_rsp("print0", 2'd3, 2'd3, 3'd0, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        chk("print0.pulse", bus_if.rsp_valid, 32'd0);

        // Back-to-back to the same line
        send(C_RD,   5, 1, 2'b00);   chk_rsp("rd_nohit", 2'd3, 2'd1, 3'd1, 2'd0, 1'b0);
        send(C_WR,   5, 1, 2'b00);   chk_rsp("wr_e",     2'd1, 2'd0, 3'd0, 2'd0, 1'b0);
        send(C_SRD,  5, 1, 2'b00);   chk_rsp("snprd_m",  2'd0, 2'd2, 3'd2, 2'd2, 1'b0);
        send(C_SRFO, 5, 1, 2'b00);   chk_rsp("rfo_s",    2'd2, 2'd3, 3'd0, 2'd1, 1'b0);

        send(C_RD,   6, 0, 2'b10);   chk_rsp("rd_hitm",  2'd3, 2'd2, 3'd1, 2'd0, 1'b0);
        send(C_WR,   6, 0, 2'b00);   chk_rsp("wr_s",     2'd2, 2'd0, 3'd3, 2'd0, 1'b0);
        send(C_WR,   7, 3, 2'b00);   chk_rsp("wr_i",     2'd3, 2'd0, 3'd4, 2'd0, 1'b0);
        send(C_IRD,  8, 0, 2'b01);   chk_rsp("ird_hit",  2'd3, 2'd2, 3'd1, 2'd0, 1'b0);
        send(C_SINV, 8, 0, 2'b00);   chk_rsp("inv_s",    2'd2, 2'd3, 3'd0, 2'd1, 1'b0);
        send(C_SINV, 6, 0, 2'b00);   chk_rsp("inv_m",    2'd0, 2'd0, 3'd0, 2'd0, 1'b0);
        send(C_SWR,  6, 0, 2'b00);   chk_rsp("snpwr_m",  2'd0, 2'd0, 3'd0, 2'd0, 1'b0);
        send(C_SRFO, 7, 3, 2'b00);   chk_rsp("rfo_m",    2'd0, 2'd3, 3'd2, 2'd2, 1'b0);
        send(C_SRD,  8, 0, 2'b00);   chk_rsp("snprd_i",  2'd3, 2'd3, 3'd0, 2'd0, 1'b0);
        send(C_RD,   6, 0, 2'b00);   chk_rsp("rd_m",     2'd0, 2'd0, 3'd0, 2'd0, 1'b0);

        // Illegal codes and snoop_in = 11 leave state alone
        send(4'b1011, 6, 0, 2'b00);  chk_rsp("ill_1011",  2'd0, 2'd0, 3'd0, 2'd0, 1'b1);
        send(4'b0111, 6, 0, 2'b00);  chk_rsp("ill_0111",  2'd0, 2'd0, 3'd0, 2'd0, 1'b1);
        send(C_PRINT, 6, 0, 2'b00);  chk_rsp("print_m",   2'd0, 2'd0, 3'd0, 2'd0, 1'b0);
        send(C_RD,    9, 0, 2'b11);  chk_rsp("ill_snoop", 2'd3, 2'd3, 3'd0, 2'd0, 1'b1);
        send(C_PRINT, 9, 0, 2'b00);  chk_rsp("print_i",   2'd3, 2'd3, 3'd0, 2'd0, 1'b0);

        send(C_WR,   15, 3, 2'b00);  chk_rsp("wr_last",  2'd3, 2'd0, 3'd4, 2'd0, 1'b0);
        send(C_WR,    0, 0, 2'b00);  chk_rsp("wr_first", 2'd3, 2'd0, 3'd4, 2'd0, 1'b0);

        // Clear sweep; a command offered while busy must be dropped
        send(C_CLR, 0, 0, 2'b00);
        chk("clr.busy",  bus_if.busy,      32'd1);
        chk("clr.ready", bus_if.cmd_ready, 32'd0);
        chk("clr.valid", bus_if.rsp_valid, 32'd0);
        send(C_WR, 10, 0, 2'b00);
        watch_sweep(cyc, seen);
        chk("clr.len",    cyc + 1, 32'd16);
        chk("clr.no_rsp", seen,    32'd0);
        chk("clr.busy_end", bus_if.busy, 32'd0);
        chk_rsp("clr.rsp", 2'd3, 2'd3, 3'd0, 2'd0, 1'b0);
`ifdef MESI_STATS_EN
        chk("clr.hit_cnt",  bus_if.hit_cnt,  32'd0);
        chk("clr.miss_cnt", bus_if.miss_cnt, 32'd0);
        chk("clr.wb_cnt",   bus_if.wb_cnt,   32'd0);
`endif
        @(posedge clk);
        #1;
        chk("clr.pulse", bus_if.rsp_valid, 32'd0);
        for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                send(C_PRINT, s, w, 2'b00);
                chk($sformatf("clr.s%0dw%0d", s, w), bus_if.rsp_next_state, 32'd3);
            end
        end

        // Reset at sweep cycle 7: sweep restarts, no clear response
        send(C_WR,  0, 0, 2'b00);    chk_rsp("wr2_first", 2'd3, 2'd0, 3'd4, 2'd0, 1'b0);
        send(C_WR, 15, 3, 2'b00);    chk_rsp("wr2_last",  2'd3, 2'd0, 3'd4, 2'd0, 1'b0);
        send(C_CLR, 0, 0, 2'b00);
        chk("rclr.busy", bus_if.busy, 32'd1);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rclr.rst_busy",  bus_if.busy,      32'd0);
        chk("rclr.rst_ready", bus_if.cmd_ready, 32'd0);
        chk("rclr.rst_valid", bus_if.rsp_valid, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        watch_sweep(cyc, seen);
        chk("rclr.len",        cyc,              32'd16);
        chk("rclr.no_rsp",     seen,             32'd0);
        chk("rclr.no_rsp_end", bus_if.rsp_valid, 32'd0);
        send(C_PRINT, 15, 3, 2'b00); chk_rsp("rclr.last",  2'd3, 2'd3, 3'd0, 2'd0, 1'b0);
        send(C_PRINT,  0, 0, 2'b00); chk_rsp("rclr.first", 2'd3, 2'd3, 3'd0, 2'd0, 1'b0);

        // Three misses, two hits, one writeback
        send(C_RD,  1, 0, 2'b00);    chk_rsp("st.miss0", 2'd3, 2'd1, 3'd1, 2'd0, 1'b0);
        send(C_RD,  1, 1, 2'b00);    chk_rsp("st.miss1", 2'd3, 2'd1, 3'd1, 2'd0, 1'b0);
        send(C_IRD, 1, 2, 2'b01);    chk_rsp("st.miss2", 2'd3, 2'd2, 3'd1, 2'd0, 1'b0);
        send(C_RD,  1, 0, 2'b00);    chk_rsp("st.hit0",  2'd1, 2'd1, 3'd0, 2'd0, 1'b0);
        send(C_WR,  1, 1, 2'b00);    chk_rsp("st.hit1",  2'd1, 2'd0, 3'd0, 2'd0, 1'b0);
        send(C_SRD, 1, 1, 2'b00);    chk_rsp("st.wb",    2'd0, 2'd2, 3'd2, 2'd2, 1'b0);
`ifdef MESI_STATS_EN
        chk("st.hit_cnt",  bus_if.hit_cnt,  32'd2);
        chk("st.miss_cnt", bus_if.miss_cnt, 32'd3);
        chk("st.wb_cnt",   bus_if.wb_cnt,   32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mesi_line_state_ctrl.md
Name: mesi_line_state_ctrl

Overview:
- Sequential, parametrised MESI state keeper for the set-associative L2: holds a 2-bit MESI state per (set, way) line.
- Accepts L1/snoop commands over a valid/ready handshake and applies the protocol transition.
- Returns previous/next state, required bus operation and snoop result one cycle later.
- Supports a multi-cycle clear sweep. Sits between the L2 tag/hit logic and the bus interface.

Parameters:
- NUM_SETS, 16, number of sets; power of 2, ≥2
- NUM_WAYS, 4, ways per set; power of 2, ≥1
- CNT_W, 16, width of statistics counters (MESI_STATS_EN only)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command this cycle
- cmd_code  in  4  command: 0000 L1 read, 0001 L1 write, 0010 L1 instr read, 0011 snoop invalidate, 0100 snoop read, 0101 snoop write, 0110 snoop RFO, 1000 clear, 1001 print
- cmd_set  in  $clog2(NUM_SETS)  set index
- cmd_way  in  max(1,$clog2(NUM_WAYS))  way index (tag logic supplies the hit or victim way)
- snoop_in  in  2  other caches' snoop result for our bus read: 00 noHIT, 01 HIT, 10 HITM
- rsp_valid  out  1  response pulse
- rsp_prev_state  out  2  state before command: M=00, E=01, S=10, I=11
- rsp_next_state  out  2  state after command
- rsp_bus_op  out  3  0 NONE, 1 READ, 2 WRITE(back), 3 INVALIDATE, 4 RWIM
- rsp_snoop_out  out  2  our snoop result (noHIT/HIT/HITM)
- rsp_illegal  out  1  unknown cmd_code or snoop_in=11
- busy  out  1  clear/reset sweep in progress

Behaviour:
- Reset:
  - Outputs are all 0, except rsp_prev_state/rsp_next_state = I and cmd_ready = 0.
  - On the first cycle after rst falls, a sweep starts that writes I to every line. No response is produced for the reset sweep.
- Accept = cmd_valid & cmd_ready in cycle T. State is read and the next state is written in T. The response is registered and visible in T+1 for exactly one cycle.
- Throughput: 1 command per cycle. Back-to-back commands to the same line see the updated state.
- cmd_ready = !busy & !rst.
- L1 read / L1 instr read:
  - I → E if snoop_in = noHIT; I → S if HIT or HITM. bus_op READ.
  - M, E, S unchanged; NONE.
- L1 write:
  - I → M, RWIM.
  - S → M, INVALIDATE.
  - E → M, NONE.
  - M → M, NONE.
- Snoop invalidate: S → I, snoop_out HIT. Other states unchanged, noHIT.
- Snoop read:
  - M → S, HITM, bus_op WRITE.
  - E → S, HIT.
  - S → S, HIT.
  - I → I, noHIT.
- Snoop write: no change, noHIT.
- Snoop RFO:
  - M → I, HITM, WRITE.
  - E → I, HIT.
  - S → I, HIT.
  - I → I, noHIT.
- Print: no change; response returns the current state.
- Illegal cmd_code (0111, 1010–1111) or snoop_in = 11: no state change, rsp_illegal = 1, bus_op NONE, snoop_out noHIT.
- Clear sweep:
  - Accepted clear raises busy in T+1 and clears one set (all ways) per cycle for NUM_SETS cycles.
  - busy falls after the last set. rsp_valid pulses the cycle after the last set, with bus_op NONE and prev = next = I.
- rst during a sweep or response: the sweep restarts from set 0; any pending response is dropped.
- cmd_valid without ready is ignored, not queued.

Optional Feature:
- MESI_STATS_EN defined: adds outputs hit_cnt, miss_cnt, wb_cnt, each CNT_W bits, reset to 0.
  - hit_cnt increments on L1 read/write/instr-read to a non-I line.
  - miss_cnt increments on the same commands to an I line.
  - wb_cnt increments on responses with bus_op WRITE.
  - Counters saturate at all-ones. The clear sweep also zeroes them.
- MESI_STATS_EN undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package mesi_pkg holds:
  - state, command, snoop-result and bus-op encodings as typed constants;
  - the illegal-command range check.
- One combinational sub-module, mesi_next_state: inputs present state, command, snoop_in; outputs next state, bus_op, snoop_out, illegal.
- The top module holds the state array, sweep counter, handshake and response registers.

Test Plan:
- After reset, wait until busy=0; print set 3 way 2 → rsp_prev_state = rsp_next_state = 11 (I), cmd_ready=1.
- L1 read set 5 way 1, snoop_in=00 → next E, bus_op 1. Then L1 write to the same line the next cycle → prev E, next M, bus_op 0.
- Line in M; snoop read → next S, snoop_out 10, bus_op 2. Then snoop RFO → prev S, next I, snoop_out 01.
- L1 read to I with snoop_in=10 → next S. L1 write → next M, bus_op 3. L1 write to another I line → bus_op 4.
- Clear with NUM_SETS=16 → busy high for 16 cycles, cmd_ready=0, rsp_valid one cycle later. Every line then prints I. Assert rst at sweep cycle 7 → sweep restarts, no clear response.
- cmd_code 1011 → rsp_illegal=1, state unchanged. With MESI_STATS_EN: 3 misses and 2 hits give miss_cnt=3, hit_cnt=2.
